// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, radix check and counter width helper for the seg7 counter
package seg7_pkg;
  localparam logic [111:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return GLYPH_TAB[7*nib +: 7];
  endfunction
  function automatic bit radix_ok(input int r);
    return r == 10 || r == 16;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: one counter digit with inc/dec, carry/borrow chain and sync clear
module seg7_digit
  import seg7_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       clear_i,
  output logic [3:0] val_o,
  output logic       co_o
);
  localparam logic [3:0] TOP = 4'(RADIX - 1);
  logic [3:0] val_q, val_d;
  logic       at_end;
  assign at_end = up_i ? val_q == TOP : val_q == 4'd0;
  assign co_o   = step_i && at_end;
  assign val_o  = val_q;
  // clear wins; a step wraps at the radix limits and otherwise moves by one
  always_comb
    val_d = clear_i ? 4'd0 : !step_i ? val_q : at_end ? (up_i ? 4'd0 : TOP) :
            up_i ? val_q + 4'd1 : val_q - 4'd1;
  // digit register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) val_q <= '0;
    else val_q <= val_d;
endmodule

// File: rtl/seg7_multi_counter.sv
// seg7_multi_counter: prescaled multi-digit up/down counter with scanned 7-seg output
module seg7_multi_counter
  import seg7_pkg::*;
#(
  parameter int MAX_COUNT = 10_000_000,
  parameter int DIGITS    = 4,
  parameter int RADIX     = 10,
  parameter int SCAN_DIV  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              clear,
  output logic [6:0]        segments,
  output logic              dp,
  output logic [DIGITS-1:0] digit_sel,
  output logic              wrap
);
  localparam int PW  = cnt_w(MAX_COUNT);
  localparam int SW  = cnt_w(SCAN_DIV);
  localparam int IW  = cnt_w(DIGITS);
  localparam int RAD = radix_ok(RADIX) ? RADIX : 10;
  logic [PW-1:0]       pre_q, pre_d;
  logic [SW-1:0]       sc_q, sc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                hb_q, hb_d, dp_q, dp_d, wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                tick, sc_end;
  logic [DIGITS:0]     step;
  logic [4*DIGITS-1:0] dig;
  assign tick    = en && pre_q == PW'(MAX_COUNT - 1);
  assign sc_end  = sc_q == SW'(SCAN_DIV - 1);
  assign step[0] = tick;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg7_digit #(.RADIX(RAD)) u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_i (step[i]),
      .up_i   (up),
      .clear_i(clear),
      .val_o  (dig[4*i +: 4]),
      .co_o   (step[i+1])
    );
  end
  // prescaler, heartbeat, scan and output next state; segments and select share idx_d
  always_comb begin
    pre_d  = clear || tick ? '0 : en ? pre_q + PW'(1) : pre_q;
    hb_d   = !clear && (hb_q ^ tick);
    sc_d   = sc_end ? '0 : sc_q + SW'(1);
    idx_d  = !sc_end ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1);
    sel_d  = DIGITS'(1) << idx_d;
    seg_d  = glyph(4'(dig >> {idx_d, 2'b00}));
    dp_d   = idx_d == '0 && hb_q;
    wrap_d = !clear && &step[DIGITS:1];
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q  <= '0;
      sc_q   <= '0;
      idx_q  <= '0;
      hb_q   <= 1'b0;
      sel_q  <= DIGITS'(1);
      seg_q  <= 7'h3F;
      dp_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sc_q   <= sc_d;
      idx_q  <= idx_d;
      hb_q   <= hb_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      wrap_q <= wrap_d;
    end
  assign segments  = seg_q;
  assign dp        = dp_q;
  assign digit_sel = sel_q;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_seg7_multi_counter.sv
// tb_seg7_multi_counter: decimal 2-digit and hex 1-digit instances against a bench model
module tb_seg7_multi_counter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_d = 1'b0, up_d = 1'b1, clear_d = 1'b0;
  logic en_h = 1'b0, clear_h = 1'b0;
  logic [6:0] seg_d, seg_h;
  logic dp_d, dp_h, wrap_d, wrap_h;
  logic [1:0] sel_d;
  logic [0:0] sel_h;
  int total = 0, bad = 0, cyc = 0, wraps_d = 0, wraps_h = 0, w0;
  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct {
    int         n;
    logic [6:0] seg;
    logic       dp;
    int         wraps;
  } vec_t;
  vec_t vt [7];
  vec_t sb [$];
  vec_t e;

  always #5 clk = ~clk;

  seg7_multi_counter #(.MAX_COUNT(4), .DIGITS(2), .RADIX(10), .SCAN_DIV(2)) u_dec (
    .clk(clk), .rst_n(rst_n), .en(en_d), .up(up_d), .clear(clear_d),
    .segments(seg_d), .dp(dp_d), .digit_sel(sel_d), .wrap(wrap_d));

  seg7_multi_counter #(.MAX_COUNT(1), .DIGITS(1), .RADIX(16), .SCAN_DIV(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .en(en_h), .up(1'b1), .clear(clear_h),
    .segments(seg_h), .dp(dp_h), .digit_sel(sel_h), .wrap(wrap_h));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrap_d) wraps_d++;
    if (wrap_h) wraps_h++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    en_d = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    en_d = 1'b0;
  endtask

  task automatic show(input int d1, input int d0, input logic hb, input int n, input string name);
    int idx;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idx = (cyc / 2) % 2;
      chk({name, " sel"}, 32'(sel_d), 32'(2'b01 << idx));
      chk({name, " seg"}, 32'(seg_d), 32'(gl[idx != 0 ? d1 : d0]));
      chk({name, " dp"}, 32'(dp_d), 32'(idx == 0 ? hb : 1'b0));
    end
  endtask

  initial begin
    vt = '{'{10, 7'h77, 1'b0, 0}, '{5, 7'h71, 1'b1, 0}, '{1, 7'h3F, 1'b0, 1},
           '{12, 7'h39, 1'b0, 1}, '{1, 7'h5E, 1'b1, 1}, '{3, 7'h3F, 1'b0, 2},
           '{17, 7'h06, 1'b1, 3}};
    @(posedge clk);
    #2;
    chk("rst sel", 32'(sel_d), 32'h1);
    chk("rst seg", 32'(seg_d), 32'h3F);
    chk("rst dp", 32'(dp_d), 32'h0);
    chk("rst wrap", 32'(wrap_d), 32'h0);
    chk("rst hex seg", 32'(seg_h), 32'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    run(40);
    show(1, 0, 1'b0, 4, "count10");
    run(356);
    show(9, 9, 1'b1, 4, "count99");
    chk("no wrap before 99", 32'(wraps_d), 32'd0);
    run(4);
    #1;
    chk("wrap up pulse", 32'(wraps_d), 32'd1);
    show(0, 0, 1'b0, 4, "wrap00");
    run(15);
    show(0, 3, 1'b1, 4, "count03");
    w0 = wraps_d;
    clear_d = 1'b1;
    en_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_d = 1'b0;
    en_d = 1'b0;
    show(0, 0, 1'b0, 4, "clear+tick");
    chk("clear no wrap", 32'(wraps_d), 32'(w0));
    run(3);
    show(0, 0, 1'b0, 20, "en0 hold");
    run(1);
    show(0, 1, 1'b1, 4, "tick after clear");
    foreach (vt[i]) begin
      en_h = 1'b1;
      repeat (vt[i].n) @(posedge clk);
      @(negedge clk);
      en_h = 1'b0;
      sb.push_back(vt[i]);
      @(negedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("hex[%0d] seg", i), 32'(seg_h), 32'(e.seg));
      chk($sformatf("hex[%0d] dp", i), 32'(dp_h), 32'(e.dp));
      chk($sformatf("hex[%0d] wraps", i), 32'(wraps_h), 32'(e.wraps));
      chk($sformatf("hex[%0d] sel", i), 32'(sel_h), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    up_d = 1'b0;
    w0 = wraps_d;
    run(4);
    #1;
    chk("wrap down pulse", 32'(wraps_d), 32'(w0 + 1));
    show(9, 9, 1'b1, 4, "down99");
    run(4);
    show(9, 8, 1'b0, 4, "down98");
    chk("no wrap at 98", 32'(wraps_d), 32'(w0 + 1));
    en_d = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async sel", 32'(sel_d), 32'h1);
    chk("async seg", 32'(seg_d), 32'h3F);
    chk("async wrap", 32'(wrap_d), 32'h0);
    chk("async dp", 32'(dp_d), 32'h0);
    chk("async hex seg", 32'(seg_h), 32'h3F);
    @(negedge clk);
    en_d = 1'b0;
    rst_n = 1'b1;
    show(0, 0, 1'b0, 4, "after async rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
